eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
- Wishbone slave that accepts byte writes from the frame-loading bus master and buffers one Ethernet frame body.
- On command it transmits the frame byte-wise to the MAC/PHY byte interface: 7×0x55 preamble, 0xD5 SFD, buffered bytes, then a 4-byte CRC-32 FCS that the block computes.
- Enforces an inter-frame gap after each frame.
- Sits directly downstream of the frame-loading master on the same 8-bit Wishbone bus.

Parameters:
- DEPTH, 256, frame buffer size in bytes (power of two); holds buffered bytes excluding FCS.
- IFG_BYTES, 12, idle byte-times after FCS before the next frame can start.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_wb_cyc  input  1  bus cycle
- i_wb_stb  input  1  strobe
- i_wb_we  input  1  write enable
- i_wb_addr  input  2  register select: 0 DATA, 1 LEN, 2 STATUS, 3 CMD
- i_wb_data  input  8  write data
- o_wb_ack  output  1  access acknowledge
- o_wb_stall  output  1  access not accepted this cycle
- o_wb_data  output  8  read data
- o_tx_valid  output  1  o_tx_data valid
- o_tx_data  output  8  transmit byte
- i_tx_ready  input  1  sink accepts byte
- o_busy  output  1  state != S_IDLE

Behaviour:
- **Reset:** all outputs 0, state S_IDLE, wr_ptr=0, len=0, crc=32'hFFFFFFFF, ovf=0, err=0.
- **Bus acceptance:** an access is accepted when cyc&stb&!o_wb_stall. o_wb_ack=1 exactly one cycle after each accepted access, otherwise 0.
- **Stall:** o_wb_stall = (state != S_IDLE), registered. Accesses presented while stalled have no effect and get no ack.
- **Write addr 0 (DATA):** if wr_ptr < DEPTH, buf[wr_ptr] <= data and wr_ptr++. Otherwise drop the byte and set ovf.
- **Write addr 1 (LEN):** len <= data. len is the index of the last frame byte including FCS. Payload count = len-3.
- **Write addr 2:** ignored.
- **Write addr 3 (CMD):**
  - If len < 3, or (len-3) > wr_ptr: set err, stay S_IDLE, keep wr_ptr.
  - Otherwise clear err, rd_ptr <= 0, cnt <= 0, crc <= FFFFFFFF, go to S_PREAMBLE.
- **Read addr 2 (STATUS):** o_wb_data = {5'b0, ovf, err, busy}, valid with ack. Reads of any other address return 0. Reads do not clear flags.
- **CMD while busy:** impossible, because the access is stalled.
- **Transmit handshake:** a byte is held stable with o_tx_valid=1 until i_tx_ready. It advances only on valid&ready. Back-to-back bytes are allowed; there are no bubbles while the sink is ready.
- **States:**
  - S_IDLE: o_tx_valid=0.
  - S_PREAMBLE: 0x55 ×7 (cnt 0..6), then S_SFD.
  - S_SFD: 0xD5 ×1, then S_DATA; go directly to S_FCS if payload count = 0.
  - S_DATA: buf[rd_ptr]. On each accept, crc <= crc_update(crc, byte) and rd_ptr++. After byte index len-4, go to S_FCS.
  - S_FCS: 4 bytes, byte k = ~crc[8k+7:8k], k = 0..3, LSB first. After k=3, go to S_IFG.
  - S_IFG: o_tx_valid=0 for IFG_BYTES cycles. Then wr_ptr <= 0, ovf <= 0, go to S_IDLE.
- **CRC:** reflected CRC-32, polynomial 0xEDB88320, init FFFFFFFF, 8 bit-steps per byte, all combinational within one cycle.
- **Latency:** CMD ack cycle → first 0x55 valid on the next cycle.
- **Reset mid-frame:** on the next edge go to S_IDLE, drop valid, discard buffer contents (wr_ptr=0).

Test Plan:
- Write DATA "123456789" (0x31..0x39), LEN=12, CMD → 0x55×7, 0xD5, 0x31..0x39, FCS 0x26 0x39 0xF4 0xCB; then valid=0 for 12 cycles; busy falls; stall falls.
- Same frame with i_tx_ready toggling 1/0 every cycle → identical byte sequence; o_tx_data stable while ready=0.
- 60 DATA writes, LEN=63, CMD; then a DATA write during transmit → write stalled, no ack; transmitted frame is 8+60+4 bytes.
- LEN=2, CMD → no tx_valid; STATUS read = 0x02. Then LEN=5 with 0 bytes written, CMD → err stays; STATUS = 0x02.
- DEPTH+1 DATA writes → STATUS = 0x04; last byte not stored; ovf cleared after the next completed frame.
- rst asserted during S_DATA → next cycle o_tx_valid=0, o_busy=0, o_wb_stall=0; STATUS read = 0x00.

Source files
------------

// File: rtl/eth_tx_framer.sv
// ============================================================================
// eth_tx_framer
// ----------------------------------------------------------------------------
// Wishbone-loaded Ethernet transmit framer. The frame-loading master writes
// the frame body one byte at a time into an internal buffer, programs the
// frame length and issues a start command. The framer then streams the frame
// to the MAC/PHY byte interface:
//
//     7 x 0x55 preamble, 0xD5 SFD, buffered payload bytes, 4-byte FCS
//
// The FCS is the reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF) of the
// payload, complemented and sent least significant byte first. After the
// last FCS byte is accepted the line is held idle for IFG_BYTES cycles before
// the buffer is released for the next frame.
//
// Register map (8-bit Wishbone, word address i_wb_addr):
//     0 DATA   write: append byte to buffer (sets ovf when buffer is full)
//     1 LEN    write: index of last frame byte including FCS (payload = LEN-3)
//     2 STATUS read : {5'b0, ovf, err, busy}
//     3 CMD    write: start transmission (sets err if LEN is inconsistent)
//
// Ports:
//     clk          clock
//     rst          synchronous active-high reset
//     i_wb_cyc     Wishbone cycle
//     i_wb_stb     Wishbone strobe
//     i_wb_we      Wishbone write enable
//     i_wb_addr    register select
//     i_wb_data    write data
//     o_wb_ack     acknowledge, one cycle after each accepted access
//     o_wb_stall   high whenever a frame is in flight (state != S_IDLE)
//     o_wb_data    read data, valid together with o_wb_ack
//     o_tx_valid   o_tx_data holds a byte for the sink
//     o_tx_data    transmit byte
//     i_tx_ready   sink accepts the byte this cycle
//     o_busy       state != S_IDLE
// ============================================================================
module eth_tx_framer #(
    parameter int DEPTH     = 256,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wb_cyc,
    input  logic       i_wb_stb,
    input  logic       i_wb_we,
    input  logic [1:0] i_wb_addr,
    input  logic [7:0] i_wb_data,
    output logic       o_wb_ack,
    output logic       o_wb_stall,
    output logic [7:0] o_wb_data,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    output logic       o_busy
);

    // Buffer address width and a pointer one bit wider so "full" is just
    // the top bit (DEPTH is a power of two).
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Common width for length arithmetic: wide enough for both the 8-bit
    // LEN register and the buffer pointers.
    localparam int CW = (PW > 9) ? PW : 9;

    // Shared sequencing counter: preamble (0..6), FCS (0..3), IFG cycles.
    localparam int NW = $clog2(IFG_BYTES + 8);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_LEN    = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CMD    = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_FCS      = 3'd4;
    localparam logic [2:0] S_IFG      = 3'd5;

    logic [2:0]    state;
    logic [7:0]    frame_buf [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    len;
    logic [31:0]   crc;
    logic [NW-1:0] cnt;
    logic          ovf;
    logic          err;

    logic          accept;
    logic          len_short;
    logic          cmd_ok;
    logic [CW-1:0] payload_cnt;
    logic [CW-1:0] last_idx;
    logic          tx_active;
    logic [7:0]    tx_byte;
    logic          tx_load;
    logic          emit;

    // One byte of reflected CRC-32, all eight bit steps unrolled.
    function automatic logic [31:0] crc_update(input logic [31:0] c_in,
                                               input logic [7:0]  d);
        logic [31:0] c;
        c = c_in ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Stall and busy both come straight from the state register, so the bus
    // is blocked for the whole frame including the inter-frame gap.
    assign o_busy     = (state != S_IDLE);
    assign o_wb_stall = o_busy;
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;

    // LEN counts the FCS, so the payload is LEN-3 bytes and the last payload
    // byte sits at index LEN-4. A start is refused if LEN cannot hold an FCS
    // or the payload would read past the bytes actually written.
    assign len_short   = (len < 8'd3);
    assign payload_cnt = CW'(len) - CW'(3);
    assign last_idx    = CW'(len) - CW'(4);
    assign cmd_ok      = !len_short && (payload_cnt <= CW'(wr_ptr));

    // Byte the sequencer wants to present next, chosen by state. The FCS
    // is the complemented running CRC, least significant byte first.
    always_comb begin
        tx_byte   = 8'h00;
        tx_active = 1'b0;
        case (state)
            S_PREAMBLE: begin
                tx_byte   = 8'h55;
                tx_active = 1'b1;
            end
            S_SFD: begin
                tx_byte   = 8'hD5;
                tx_active = 1'b1;
            end
            S_DATA: begin
                tx_byte   = frame_buf[rd_ptr[AW-1:0]];
                tx_active = 1'b1;
            end
            S_FCS: begin
                tx_active = 1'b1;
                case (cnt[1:0])
                    2'd0:    tx_byte = ~crc[7:0];
                    2'd1:    tx_byte = ~crc[15:8];
                    2'd2:    tx_byte = ~crc[23:16];
                    default: tx_byte = ~crc[31:24];
                endcase
            end
            default: begin
                tx_byte   = 8'h00;
                tx_active = 1'b0;
            end
        endcase
    end

    // The output register refills whenever it is empty or its byte is being
    // taken, which keeps bytes back-to-back while the sink is ready. The
    // sequencer advances when a byte is loaded into the output register; by
    // the time FCS byte 0 is loaded the last payload byte has already been
    // folded into the CRC.
    assign tx_load = !o_tx_valid || i_tx_ready;
    assign emit    = tx_load && tx_active;

    // Frame buffer write port. Only reachable while idle, so it never races
    // the transmit read.
    always_ff @(posedge clk) begin
        if (!rst && accept && i_wb_we && (i_wb_addr == A_DATA) && !wr_ptr[AW]) begin
            frame_buf[wr_ptr[AW-1:0]] <= i_wb_data;
        end
    end

    // Bus register file and transmit sequencer. Bus accesses are only
    // accepted in S_IDLE, so bus-side and transmit-side updates of shared
    // registers (wr_ptr, ovf, err, state) never collide in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len        <= 8'h00;
            crc        <= CRC_INIT;
            cnt        <= '0;
            ovf        <= 1'b0;
            err        <= 1'b0;
            o_wb_ack   <= 1'b0;
            o_wb_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
        end else begin
            o_wb_ack  <= accept;
            o_wb_data <= 8'h00;

            if (accept && !i_wb_we && (i_wb_addr == A_STATUS)) begin
                o_wb_data <= {5'b00000, ovf, err, o_busy};
            end

            if (accept && i_wb_we) begin
                case (i_wb_addr)
                    A_DATA: begin
                        if (!wr_ptr[AW]) begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    A_LEN: begin
                        len <= i_wb_data;
                    end
                    A_CMD: begin
                        if (cmd_ok) begin
                            err    <= 1'b0;
                            rd_ptr <= '0;
                            cnt    <= '0;
                            crc    <= CRC_INIT;
                            state  <= S_PREAMBLE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (emit) begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= tx_byte;
                case (state)
                    S_PREAMBLE: begin
                        if (cnt == NW'(6)) begin
                            cnt   <= '0;
                            state <= S_SFD;
                        end else begin
                            cnt <= cnt + NW'(1);
                        end
                    end
                    S_SFD: begin
                        cnt   <= '0;
                        state <= (payload_cnt == '0) ? S_FCS : S_DATA;
                    end
                    S_DATA: begin
                        crc    <= crc_update(crc, tx_byte);
                        rd_ptr <= rd_ptr + PW'(1);
                        if (CW'(rd_ptr) == last_idx) begin
                            cnt   <= '0;
                            state <= S_FCS;
                        end
                    end
                    S_FCS: begin
                        if (cnt == NW'(3)) begin
                            cnt   <= '0;
                            state <= S_IFG;
                        end else begin
                            cnt <= cnt + NW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (tx_load) begin
                o_tx_valid <= 1'b0;
            end

            // The gap is counted only once the last FCS byte has actually
            // left the output register, so a slow sink cannot shorten it.
            if ((state == S_IFG) && !o_tx_valid) begin
                if (cnt == NW'(IFG_BYTES - 1)) begin
                    cnt    <= '0;
                    wr_ptr <= '0;
                    ovf    <= 1'b0;
                    state  <= S_IDLE;
                end else begin
                    cnt <= cnt + NW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// ============================================================================
// tb_eth_tx_framer
// ----------------------------------------------------------------------------
// Self-checking bench for eth_tx_framer. A table of register accesses covers
// reset values, ignored/zero reads and the LEN/CMD error cases; hand-written
// sequences cover full frames (back-to-back and with a throttling sink), the
// bus stall during transmission, buffer overflow and reset mid-frame.
// Expected frames are built from the bench's own bit-serial CRC model.
// ============================================================================
module tb_eth_tx_framer;

    localparam int DEPTH = 256;
    localparam int IFG   = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_wb_cyc;
    logic       i_wb_stb;
    logic       i_wb_we;
    logic [1:0] i_wb_addr;
    logic [7:0] i_wb_data;
    logic       o_wb_ack;
    logic       o_wb_stall;
    logic [7:0] o_wb_data;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       i_tx_ready;
    logic       o_busy;

    always #5 clk = ~clk;

    eth_tx_framer #(
        .DEPTH     (DEPTH),
        .IFG_BYTES (IFG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy)
    );

    typedef struct {
        logic [1:0] addr;
        logic       we;
        logic [7:0] data;
        logic [7:0] exp_rdata;
    } vec_t;

    int         checks_total  = 0;
    int         checks_passed = 0;
    int         valid_seen    = 0;
    int         rx_count;
    int         exp_count;
    int         unstable;
    int         first_valid;
    logic [7:0] payload   [0:511];
    logic [7:0] rx_bytes  [0:511];
    logic [7:0] exp_bytes [0:511];
    vec_t       vecs      [16];

    // Counts every cycle the transmitter presents a byte, used to prove
    // refused commands never start a frame.
    always @(negedge clk) begin
        if (o_tx_valid === 1'b1) valid_seen++;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One Wishbone access presented for a single cycle; ack and read data
    // are sampled just after the following clock edge.
    task automatic apply_stimulus(input logic [1:0] addr, input logic we,
                                  input logic [7:0] data,
                                  output logic ack, output logic [7:0] rdata);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        @(posedge clk);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        ack   = o_wb_ack;
        rdata = o_wb_data;
    endtask

    // Bit-serial reflected CRC-32 over payload[0..n-1].
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ payload[i][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic build_expected(input int n);
        logic [31:0] fcs;
        for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h55;
        exp_bytes[7] = 8'hD5;
        for (int i = 0; i < n; i++) exp_bytes[8 + i] = payload[i];
        fcs = ~model_crc(n);
        for (int k = 0; k < 4; k++) exp_bytes[8 + n + k] = fcs[8*k +: 8];
        exp_count = n + 12;
    endtask

    // Records bytes taken on valid&ready until n are seen or the cycle
    // budget runs out; also notes any change of a held byte.
    task automatic collect_frame(input int n, input bit toggle);
        int         cycles;
        logic       hold;
        logic [7:0] held;
        rx_count    = 0;
        unstable    = 0;
        first_valid = -1;
        hold        = 1'b0;
        held        = 8'h00;
        cycles      = 0;
        i_tx_ready  = 1'b1;
        while (rx_count < n && cycles < 2000) begin
            @(negedge clk);
            if (hold && (o_tx_valid !== 1'b1 || o_tx_data !== held)) unstable++;
            if (o_tx_valid === 1'b1 && first_valid < 0) first_valid = cycles;
            hold = (o_tx_valid === 1'b1) && !i_tx_ready;
            held = o_tx_data;
            if (o_tx_valid === 1'b1 && i_tx_ready) begin
                rx_bytes[rx_count] = o_tx_data;
                rx_count++;
            end
            cycles++;
            if (rx_count < n) begin
                @(posedge clk);
                #1;
                if (toggle) i_tx_ready = ~i_tx_ready;
            end
        end
        if (rx_count < n) $display("[TB] frame byte budget expired after %0d bytes", rx_count);
        i_tx_ready = 1'b1;
    endtask

    task automatic compare_frame(input string name);
        check_output({name, "_len"}, 32'(rx_count), 32'(exp_count));
        for (int i = 0; i < exp_count; i++) begin
            check_output($sformatf("%s_byte%0d", name, i), 32'(rx_bytes[i]), 32'(exp_bytes[i]));
        end
    endtask

    task automatic check_ifg(input string name);
        int gap  = 0;
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (o_busy === 1'b1 && o_tx_valid === 1'b0) gap++;
            else done = 1'b1;
        end
        check_output({name, "_ifg"}, 32'(gap), 32'(IFG));
        check_output({name, "_busy_low"}, 32'(o_busy), 32'd0);
        check_output({name, "_stall_low"}, 32'(o_wb_stall), 32'd0);
    endtask

    task automatic write_payload(input int n);
        logic       ack;
        logic [7:0] rd;
        int         missed = 0;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(2'd0, 1'b1, payload[i], ack, rd);
            if (ack !== 1'b1) missed++;
        end
        check_output("data_write_acks", 32'(missed), 32'd0);
    endtask

    task automatic start_frame(input logic [7:0] len_val);
        logic       ack;
        logic [7:0] rd;
        apply_stimulus(2'd1, 1'b1, len_val, ack, rd);
        apply_stimulus(2'd3, 1'b1, 8'h00, ack, rd);
        check_output("cmd_ack", 32'(ack), 32'd1);
    endtask

    task automatic send_frame(input int n, input logic [7:0] len_val,
                              input bit toggle, input string name);
        start_frame(len_val);
        collect_frame(n + 12, toggle);
        build_expected(n);
        compare_frame(name);
        check_output({name, "_latency"}, 32'(first_valid), 32'd1);
        check_output({name, "_stable"}, 32'(unstable), 32'd0);
        check_ifg(name);
    endtask

    task automatic read_status(input string name, input logic [7:0] expected);
        logic       ack;
        logic [7:0] rd;
        apply_stimulus(2'd2, 1'b0, 8'h00, ack, rd);
        check_output({name, "_ack"}, 32'(ack), 32'd1);
        check_output(name, 32'(rd), 32'(expected));
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         seen_before;

        rst        = 1'b1;
        i_wb_cyc   = 1'b0;
        i_wb_stb   = 1'b0;
        i_wb_we    = 1'b0;
        i_wb_addr  = 2'd0;
        i_wb_data  = 8'h00;
        i_tx_ready = 1'b1;

        // Reset values, sampled while reset is still applied.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_wb_ack",   32'(o_wb_ack),   32'd0);
        check_output("rst_wb_stall", 32'(o_wb_stall), 32'd0);
        check_output("rst_wb_data",  32'(o_wb_data),  32'd0);
        check_output("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_output("rst_tx_data",  32'(o_tx_data),  32'd0);
        check_output("rst_busy",     32'(o_busy),     32'd0);
        rst = 1'b0;

        // Register-level vectors: zero reads, ignored STATUS write and the
        // two refused starts (LEN too short, payload longer than written).
        vecs[0]  = '{2'd2, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{2'd0, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{2'd1, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{2'd1, 1'b1, 8'h02, 8'h00};
        vecs[4]  = '{2'd1, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{2'd2, 1'b1, 8'hFF, 8'h00};
        vecs[6]  = '{2'd2, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{2'd3, 1'b1, 8'h00, 8'h00};
        vecs[8]  = '{2'd2, 1'b0, 8'h00, 8'h02};
        vecs[9]  = '{2'd3, 1'b0, 8'h00, 8'h00};
        vecs[10] = '{2'd1, 1'b1, 8'h05, 8'h00};
        vecs[11] = '{2'd3, 1'b1, 8'h00, 8'h00};
        vecs[12] = '{2'd2, 1'b0, 8'h00, 8'h02};
        vecs[13] = '{2'd0, 1'b1, 8'hAB, 8'h00};
        vecs[14] = '{2'd3, 1'b1, 8'h00, 8'h00};
        vecs[15] = '{2'd2, 1'b0, 8'h00, 8'h02};

        seen_before = valid_seen;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].we, vecs[i].data, ack, rd);
            check_output($sformatf("vec%0d_ack", i), 32'(ack), 32'd1);
            check_output($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
        end
        repeat (4) @(posedge clk);
        #1;
        check_output("refused_cmd_no_tx", 32'(valid_seen - seen_before), 32'd0);
        check_output("refused_cmd_not_busy", 32'(o_busy), 32'd0);

        // Zero-length payload (one byte still buffered from the table):
        // SFD goes straight to an all-zero FCS. Also clears err.
        $display("[TB] empty payload frame");
        send_frame(0, 8'd3, 1'b0, "empty");
        read_status("empty_status", 8'h00);

        // Reference frame "123456789" with its well-known FCS.
        $display("[TB] reference frame");
        for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
        write_payload(9);
        send_frame(9, 8'd12, 1'b0, "ref");
        check_output("ref_fcs0", 32'(rx_bytes[17]), 32'h26);
        check_output("ref_fcs1", 32'(rx_bytes[18]), 32'h39);
        check_output("ref_fcs2", 32'(rx_bytes[19]), 32'hF4);
        check_output("ref_fcs3", 32'(rx_bytes[20]), 32'hCB);

        // Same frame against a sink toggling ready every cycle.
        $display("[TB] throttled sink");
        write_payload(9);
        send_frame(9, 8'd12, 1'b1, "toggle");

        // 60-byte frame with a DATA write attempted mid-transmission.
        $display("[TB] stalled write during transmit");
        for (int i = 0; i < 60; i++) payload[i] = 8'(i * 7 + 3);
        write_payload(60);
        start_frame(8'd63);
        fork
            collect_frame(72, 1'b0);
            begin
                logic       s_ack;
                logic [7:0] s_rd;
                repeat (20) @(posedge clk);
                #1;
                check_output("mid_tx_stall", 32'(o_wb_stall), 32'd1);
                apply_stimulus(2'd0, 1'b1, 8'hEE, s_ack, s_rd);
                check_output("mid_tx_write_ack", 32'(s_ack), 32'd0);
            end
        join
        build_expected(60);
        compare_frame("long");
        check_ifg("long");

        // Fill the buffer exactly, then one more byte: it must be dropped
        // and flag overflow; overflow clears after the next frame.
        $display("[TB] buffer overflow");
        for (int i = 0; i < DEPTH; i++) payload[i] = 8'(i) ^ 8'h5A;
        write_payload(DEPTH);
        read_status("full_status", 8'h00);
        apply_stimulus(2'd0, 1'b1, ~payload[0], ack, rd);
        check_output("ovf_write_ack", 32'(ack), 32'd1);
        read_status("ovf_status", 8'h04);
        send_frame(9, 8'd12, 1'b0, "after_ovf");
        read_status("ovf_cleared_status", 8'h00);

        // Reset in the middle of the payload, then prove the buffer was
        // released by sending a fresh frame from index 0.
        $display("[TB] reset mid-frame");
        for (int i = 0; i < 20; i++) payload[i] = 8'hC0 + 8'(i);
        write_payload(20);
        start_frame(8'd23);
        collect_frame(12, 1'b0);
        check_output("pre_rst_bytes", 32'(rx_count), 32'd12);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_output("midrst_busy",     32'(o_busy),     32'd0);
        check_output("midrst_stall",    32'(o_wb_stall), 32'd0);
        rst = 1'b0;
        read_status("midrst_status", 8'h00);
        for (int i = 0; i < 9; i++) payload[i] = 8'h90 + 8'(i * 3);
        write_payload(9);
        send_frame(9, 8'd12, 1'b0, "after_rst");

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
